conf_int_mac_dot_drv: RTL and testbench

Initiator-side sequencer for the configurable integer MAC accumulator wrapper. It accepts a handshaked stream of operand pairs and drives them into the MAC's `a`/`b` ports, feeding zeros between beats. It snapshots the MAC's free-running accumulator `d` before each vector and returns the dot product as `d_end - d_start` (mod 2^W) on a handshaked result port. No accumulator clear is needed.

---
 rtl/conf_int_mac_pkg.sv | 22 ++
 rtl/conf_int_mac_dot_drv_ctrl.sv | 124 ++++++++++++
 rtl/conf_int_mac_dot_drv.sv | 91 +++++++++
 tb/tb_conf_int_mac_dot_drv.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conf_int_mac_pkg.sv
// ---------------------------------------------------------------------------
// conf_int_mac_pkg
// Shared definitions for the integer MAC dot-product driver.
//   drv_state_e  : sequencer FSM states
//   DRAIN_CYCLES : zero-feed cycles after the last beat before the result
//                  is read from the accumulator
//   MAC_LATENCY  : edges from the driver's operand registers to the MAC
//                  accumulator (operand register stage + accumulate stage)
// ---------------------------------------------------------------------------
package conf_int_mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_RESULT = 2'd3
  } drv_state_e;

  localparam int DRAIN_CYCLES = 3;
  localparam int MAC_LATENCY  = 2;

endpackage

// File: rtl/conf_int_mac_dot_drv_ctrl.sv
// ---------------------------------------------------------------------------
// conf_int_mac_dot_drv_ctrl
// Sequencer FSM for the dot-product driver: beat handshake, beat counter,
// truncation flag, drain counter and result handshake.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid_i          : operand beat offered
//   in_last_i           : offered beat closes the vector
//   out_ready_i         : result consumer ready
//   in_ready_o          : driver accepts a beat this cycle
//   out_valid_o         : result registers hold a valid result
//   xfer_o              : a beat is transferred at the coming edge
//   start_o             : the transfer is the first beat of a vector
//   capture_o           : the accumulator holds the final sum this cycle
//   len_o, trunc_o      : beat count and truncation flag of the vector
// ---------------------------------------------------------------------------
module conf_int_mac_dot_drv_ctrl
  import conf_int_mac_pkg::*;
#(
  parameter int MAX_LEN = 256,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid_i,
  input  logic             in_last_i,
  input  logic             out_ready_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic             xfer_o,
  output logic             start_o,
  output logic             capture_o,
  output logic [LEN_W-1:0] len_o,
  output logic             trunc_o
);

  // The drain must outlast the MAC pipeline so the last beat has reached
  // the accumulator before it is read.
  localparam int DrainCycles = (DRAIN_CYCLES > MAC_LATENCY) ? DRAIN_CYCLES
                                                            : MAC_LATENCY + 1;
  localparam logic [1:0]       DrainLast = 2'(DrainCycles - 1);
  localparam logic [LEN_W-1:0] MaxLenV   = LEN_W'(MAX_LEN);

  drv_state_e       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] len_inc;
  logic             trunc_q, trunc_d;
  logic [1:0]       drain_q, drain_d;
  logic             ready;

  // Beats are only offered upstream in IDLE/STREAM and never while in reset.
  assign ready      = (state_q == ST_IDLE) || (state_q == ST_STREAM);
  assign in_ready_o = ready & ~rst;
  assign xfer_o     = in_valid_i & in_ready_o;
  assign len_inc    = len_q + LEN_W'(1);

  // State and counter registers, all cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      trunc_q <= 1'b0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      trunc_q <= trunc_d;
      drain_q <= drain_d;
    end
  end

  // Next-state logic; defaults hold everything and strobes are idle.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    trunc_d     = trunc_q;
    drain_d     = drain_q;
    start_o     = 1'b0;
    capture_o   = 1'b0;
    out_valid_o = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (xfer_o) begin
          start_o = 1'b1;
          len_d   = LEN_W'(1);
          trunc_d = 1'b0;
          state_d = in_last_i ? ST_DRAIN : ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (xfer_o) begin
          len_d = len_inc;
          if (in_last_i) begin
            state_d = ST_DRAIN;
          end else if (len_inc == MaxLenV) begin
            // Vector cut at the length limit; next beat opens a new vector.
            trunc_d = 1'b1;
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q + 2'd1;
        if (drain_q == DrainLast) begin
          capture_o = 1'b1;
          drain_d   = '0;
          state_d   = ST_RESULT;
        end
      end
      ST_RESULT: begin
        out_valid_o = 1'b1;
        if (out_ready_i) begin
          trunc_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign len_o   = len_q;
  assign trunc_o = trunc_q;

endmodule

// File: rtl/conf_int_mac_dot_drv.sv
// ---------------------------------------------------------------------------
// conf_int_mac_dot_drv
// Initiator-side driver for the configurable integer MAC. Operand pairs are
// pushed into the MAC (zeros in between), the free-running accumulator is
// sampled before and after the vector, and the difference is returned as
// the dot product modulo 2^W.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   in_valid/in_ready/in_a/in_b/in_last : operand beat stream
//   out_valid/out_ready/out_data/out_len/out_trunc : result stream
//   mac_a, mac_b                 : operands to the MAC
//   mac_d                        : MAC accumulator
// ---------------------------------------------------------------------------
module conf_int_mac_dot_drv
  import conf_int_mac_pkg::*;
#(
  parameter int  DATA_PATH_BITWIDTH = 16,
  parameter int  OP_BITWIDTH        = 16,
  parameter int  MAX_LEN            = 256,
  localparam int LEN_W              = $clog2(MAX_LEN + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_PATH_BITWIDTH-1:0] in_a,
  input  logic [DATA_PATH_BITWIDTH-1:0] in_b,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_PATH_BITWIDTH-1:0] out_data,
  output logic [LEN_W-1:0]              out_len,
  output logic                          out_trunc,
  output logic [DATA_PATH_BITWIDTH-1:0] mac_a,
  output logic [DATA_PATH_BITWIDTH-1:0] mac_b,
  input  logic [DATA_PATH_BITWIDTH-1:0] mac_d
);

  // OP_BITWIDTH only configures the MAC itself; nothing here depends on it.
  if (OP_BITWIDTH > DATA_PATH_BITWIDTH) begin : g_op_wider_than_path
  end

  logic                          xfer, start, capture;
  logic [DATA_PATH_BITWIDTH-1:0] mac_a_q, mac_b_q;
  logic [DATA_PATH_BITWIDTH-1:0] base_q;
  logic [DATA_PATH_BITWIDTH-1:0] out_data_q;

  conf_int_mac_dot_drv_ctrl #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_ctrl (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid),
    .in_last_i   (in_last),
    .out_ready_i (out_ready),
    .in_ready_o  (in_ready),
    .out_valid_o (out_valid),
    .xfer_o      (xfer),
    .start_o     (start),
    .capture_o   (capture),
    .len_o       (out_len),
    .trunc_o     (out_trunc)
  );

  // Operand registers feed zeros whenever no beat transfers so the
  // accumulator holds still; base is the accumulator snapshot at the
  // first beat, and the result is the wrapped difference at capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      mac_a_q    <= '0;
      mac_b_q    <= '0;
      base_q     <= '0;
      out_data_q <= '0;
    end else begin
      mac_a_q <= xfer ? in_a : '0;
      mac_b_q <= xfer ? in_b : '0;
      if (start) begin
        base_q <= mac_d;
      end
      if (capture) begin
        out_data_q <= mac_d - base_q;
      end
    end
  end

  assign mac_a    = mac_a_q;
  assign mac_b    = mac_b_q;
  assign out_data = out_data_q;

endmodule

// File: tb/tb_conf_int_mac_dot_drv.sv
// ---------------------------------------------------------------------------
// tb_conf_int_mac_dot_drv
// Bench for the MAC dot-product driver. A behavioural MAC (operand register
// stage plus truncating accumulator with a non-zero reset value) closes the
// loop; expected results come from a plain sum-of-products model.
// ---------------------------------------------------------------------------
module tb_conf_int_mac_dot_drv;

  localparam int W       = 16;
  localparam int MAX_LEN = 4;
  localparam int LW      = $clog2(MAX_LEN + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [W-1:0]  in_a = '0, in_b = '0;
  logic          in_ready, out_valid, out_trunc;
  logic [W-1:0]  out_data, mac_a, mac_b, mac_d;
  logic [LW-1:0] out_len;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] va [0:15];
  logic [W-1:0] vb [0:15];

  always #5 clk = ~clk;

  conf_int_mac_dot_drv #(
    .DATA_PATH_BITWIDTH (W),
    .OP_BITWIDTH        (W),
    .MAX_LEN            (MAX_LEN)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_len   (out_len),
    .out_trunc (out_trunc),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_d     (mac_d)
  );

  // Behavioural MAC: registers the operands, then accumulates the
  // W-bit-truncated product; reset (active low) leaves a non-zero sum.
  logic         mac_rst_n;
  logic [W-1:0] a_reg, b_reg, acc;
  logic [31:0]  prod;
  assign mac_rst_n = ~rst;
  assign prod      = a_reg * b_reg;
  assign mac_d     = acc;
  always_ff @(posedge clk) begin
    if (!mac_rst_n) begin
      a_reg <= '0;
      b_reg <= '0;
      acc   <= 16'h1234;
    end else begin
      a_reg <= mac_a;
      b_reg <= mac_b;
      acc   <= acc + prod[W-1:0];
    end
  end

  // Reference dot product of the first n entries of va/vb, mod 2^W.
  function automatic logic [W-1:0] dot_ref(input int n);
    logic [W-1:0] s;
    logic [31:0]  p;
    s = '0;
    for (int i = 0; i < n; i++) begin
      p = va[i] * vb[i];
      s = s + p[W-1:0];
    end
    return s;
  endfunction

  // Drives n beats from va/vb (optionally random bubbles), in_last on the
  // final beat when requested; reports how many cycles in_ready was low.
  task automatic applyStimulus(input int n, input bit with_last, input bit bubbles,
                               output int waits);
    waits = 0;
    for (int i = 0; i < n; i++) begin
      if (bubbles && $urandom_range(0, 2) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
      end
      in_valid = 1'b1;
      in_a     = va[i];
      in_b     = vb[i];
      in_last  = with_last && (i == n - 1);
      for (int w = 0; w < 40 && !in_ready; w++) begin
        @(posedge clk); @(negedge clk);
        waits++;
      end
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Counts edges from the current negedge until out_valid (bounded).
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
  endtask

  // Holds out_ready low for 'stall' cycles, noting whether the result stayed
  // put and in_ready stayed low, then completes a one-cycle handshake.
  task automatic checkOutput(input int stall, output bit held, output bit blocked);
    logic [W-1:0]  d0;
    logic [LW-1:0] l0;
    logic          t0;
    d0 = out_data; l0 = out_len; t0 = out_trunc;
    held = 1'b1; blocked = 1'b1;
    out_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== d0 || out_len !== l0 || out_trunc !== t0)
        held = 1'b0;
      if (in_ready !== 1'b0) blocked = 1'b0;
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL reset_in_ready: got %b want 0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    total++; if ({out_data, out_len, out_trunc} !== '0) begin bad++; $display("[TB] FAIL reset_result: data %h len %0d trunc %b want zeros", out_data, out_len, out_trunc); end
    total++; if ({mac_a, mac_b} !== '0) begin bad++; $display("[TB] FAIL reset_mac_ops: a %h b %h want 0", mac_a, mac_b); end
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL idle_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    int waits, lat;
    bit held, blocked;
    logic [W-1:0] exp;
    va[0] = 3; vb[0] = 4; va[1] = 5; vb[1] = 6; va[2] = 7; vb[2] = 8;
    exp = dot_ref(3);
    applyStimulus(3, 1'b1, 1'b0, waits);
    wait_result(lat);
    total++; if (lat !== 3) begin bad++; $display("[TB] FAIL basic_latency: got %0d want 3", lat); end
    total++; if (out_data !== exp) begin bad++; $display("[TB] FAIL basic_data: got %0d want %0d", out_data, exp); end
    total++; if (out_len !== LW'(3) || out_trunc !== 1'b0) begin bad++; $display("[TB] FAIL basic_len: len %0d trunc %b want 3/0", out_len, out_trunc); end
    checkOutput(0, held, blocked);
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("[TB] FAIL basic_release: valid %b ready %b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_back_to_back();
    int waits, lat;
    bit held, blocked;
    va[0] = 2; vb[0] = 2;
    applyStimulus(1, 1'b1, 1'b0, waits);
    wait_result(lat);
    total++; if (out_data !== dot_ref(1) || lat !== 3) begin bad++; $display("[TB] FAIL b2b_first: data %0d lat %0d want %0d/3", out_data, lat, dot_ref(1)); end
    checkOutput(0, held, blocked);
    va[0] = 1; vb[0] = 9; va[1] = 1; vb[1] = 1;
    applyStimulus(2, 1'b1, 1'b0, waits);
    total++; if (waits !== 0) begin bad++; $display("[TB] FAIL b2b_no_bubble: waited %0d want 0", waits); end
    wait_result(lat);
    total++; if (out_data !== dot_ref(2) || out_len !== LW'(2)) begin bad++; $display("[TB] FAIL b2b_second: data %0d len %0d want %0d/2", out_data, out_len, dot_ref(2)); end
    checkOutput(0, held, blocked);
  endtask

  task automatic test_overflow();
    int waits, lat;
    bit held, blocked;
    va[0] = 16'hFFFF; vb[0] = 16'hFFFF; va[1] = 2; vb[1] = 1;
    applyStimulus(2, 1'b1, 1'b0, waits);
    wait_result(lat);
    total++; if (out_data !== dot_ref(2)) begin bad++; $display("[TB] FAIL overflow_data: got %h want %h", out_data, dot_ref(2)); end
    checkOutput(0, held, blocked);
  endtask

  task automatic test_trunc();
    int waits, lat;
    bit held, blocked;
    logic [W-1:0] exp;
    for (int i = 0; i < MAX_LEN; i++) begin
      va[i] = W'($urandom); vb[i] = W'($urandom);
    end
    exp = dot_ref(MAX_LEN);
    applyStimulus(MAX_LEN, 1'b0, 1'b0, waits);
    wait_result(lat);
    total++; if (out_len !== LW'(MAX_LEN) || out_trunc !== 1'b1) begin bad++; $display("[TB] FAIL trunc_flag: len %0d trunc %b want %0d/1", out_len, out_trunc, MAX_LEN); end
    total++; if (out_data !== exp || lat !== 3) begin bad++; $display("[TB] FAIL trunc_data: data %h lat %0d want %h/3", out_data, lat, exp); end
    checkOutput(0, held, blocked);
    va[0] = W'($urandom); vb[0] = W'($urandom);
    applyStimulus(1, 1'b1, 1'b0, waits);
    wait_result(lat);
    total++; if (out_len !== LW'(1) || out_trunc !== 1'b0 || out_data !== dot_ref(1)) begin bad++; $display("[TB] FAIL trunc_next: len %0d trunc %b data %h want 1/0/%h", out_len, out_trunc, out_data, dot_ref(1)); end
    checkOutput(0, held, blocked);
  endtask

  task automatic test_bubble();
    int waits, lat;
    bit held, blocked;
    va[0] = 16'h0011; vb[0] = 16'h0022; va[1] = 16'h0003; vb[1] = 16'h0005;
    in_valid = 1'b1; in_a = va[0]; in_b = vb[0]; in_last = 1'b0;
    @(posedge clk); @(negedge clk);
    total++; if (mac_a !== va[0] || mac_b !== vb[0]) begin bad++; $display("[TB] FAIL bubble_drive: a %h b %h want %h %h", mac_a, mac_b, va[0], vb[0]); end
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    total++; if (mac_a !== '0 || mac_b !== '0 || in_ready !== 1'b1) begin bad++; $display("[TB] FAIL bubble_zero: a %h b %h ready %b want 0 0 1", mac_a, mac_b, in_ready); end
    in_valid = 1'b1; in_a = va[1]; in_b = vb[1]; in_last = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    wait_result(lat);
    total++; if (out_len !== LW'(2) || out_data !== dot_ref(2)) begin bad++; $display("[TB] FAIL bubble_result: len %0d data %h want 2/%h", out_len, out_data, dot_ref(2)); end
    checkOutput(0, held, blocked);
  endtask

  task automatic test_stall();
    int waits, lat;
    bit held, blocked;
    va[0] = 16'h0102; vb[0] = 16'h0304; va[1] = 16'h0506; vb[1] = 16'h0708;
    applyStimulus(2, 1'b1, 1'b0, waits);
    wait_result(lat);
    total++; if (out_data !== dot_ref(2)) begin bad++; $display("[TB] FAIL stall_data: got %h want %h", out_data, dot_ref(2)); end
    checkOutput(10, held, blocked);
    total++; if (held !== 1'b1) begin bad++; $display("[TB] FAIL stall_hold: stable %b want 1", held); end
    total++; if (blocked !== 1'b1) begin bad++; $display("[TB] FAIL stall_in_ready: stayed low %b want 1", blocked); end
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("[TB] FAIL stall_release: valid %b ready %b want 0/1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid();
    int waits, lat;
    bit held, blocked, seen;
    for (int i = 0; i < 4; i++) begin
      va[i] = W'($urandom); vb[i] = W'($urandom);
    end
    applyStimulus(2, 1'b0, 1'b0, waits);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    total++; if ({in_ready, out_valid, out_data, out_len, out_trunc, mac_a, mac_b} !== '0) begin bad++; $display("[TB] FAIL midreset_zero: ready %b valid %b data %h len %0d a %h want zeros", in_ready, out_valid, out_data, out_len, mac_a); end
    rst = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("[TB] FAIL midreset_no_result: out_valid seen %b want 0", seen); end
    va[0] = 1; vb[0] = 1;
    applyStimulus(1, 1'b1, 1'b0, waits);
    wait_result(lat);
    total++; if (out_data !== dot_ref(1) || lat !== 3) begin bad++; $display("[TB] FAIL midreset_fresh: data %h lat %0d want %h/3", out_data, lat, dot_ref(1)); end
    checkOutput(0, held, blocked);
  endtask

  task automatic test_random();
    int waits, lat, n;
    bit held, blocked, with_last, exp_trunc;
    logic [W-1:0] exp;
    for (int v = 0; v < 12; v++) begin
      n = $urandom_range(1, MAX_LEN);
      with_last = (n < MAX_LEN) ? 1'b1 : 1'($urandom_range(0, 1));
      exp_trunc = !with_last;
      for (int i = 0; i < n; i++) begin
        va[i] = W'($urandom); vb[i] = W'($urandom);
      end
      exp = dot_ref(n);
      applyStimulus(n, with_last, 1'b1, waits);
      wait_result(lat);
      total++; if (out_data !== exp || lat !== 3) begin bad++; $display("[TB] FAIL random_data[%0d]: data %h lat %0d want %h/3", v, out_data, lat, exp); end
      total++; if (out_len !== LW'(n) || out_trunc !== exp_trunc) begin bad++; $display("[TB] FAIL random_len[%0d]: len %0d trunc %b want %0d/%b", v, out_len, out_trunc, n, exp_trunc); end
      checkOutput($urandom_range(0, 3), held, blocked);
      total++; if (held !== 1'b1 || blocked !== 1'b1) begin bad++; $display("[TB] FAIL random_stall[%0d]: held %b blocked %b want 1/1", v, held, blocked); end
    end
  endtask

  // Scenario sequence; every task starts and ends just after a negedge.
  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_overflow();
    test_trunc();
    test_bubble();
    test_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
